// File: rtl/seven_seg_scanner.sv
// Multiplexed 8-digit seven-segment scanner with shadow registers, leading-zero
// blanking, per-digit blink and PWM brightness. All outputs are registered.
module seven_seg_scanner #(
    parameter int N_DIGITS     = 8,
    parameter int DIV_MAX      = 100000,
    parameter int BRIGHT_BITS  = 3,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load,
    input  logic [4*N_DIGITS-1:0]    data_in,
    input  logic [N_DIGITS-1:0]      dp_in,
    input  logic                     blank_lz,
    input  logic [N_DIGITS-1:0]      blink_en,
    input  logic [BRIGHT_BITS-1:0]   brightness,
    output logic [6:0]               segments,
    output logic                     dp,
    output logic [7:0]               anodos,
    output logic                     frame_done
);

    localparam int PW   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int FW   = $clog2(BLINK_FRAMES + 1);
    localparam int STEP = DIV_MAX / (2 ** BRIGHT_BITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV_MAX - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(N_DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [4*N_DIGITS-1:0] shadow_data;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic [PW-1:0]         presc;
    logic [2:0]            idx;
    logic [FW-1:0]         frame_cnt;
    logic                  blink_phase;

    logic tick, frame_wrap;
    assign tick       = (presc == PRESC_LAST);
    assign frame_wrap = tick && (idx == IDX_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            presc       <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (load) begin
                shadow_data <= data_in;
                shadow_dp   <= dp_in;
            end
            presc <= tick ? '0 : presc + PW'(1);
            if (tick)
                idx <= frame_wrap ? 3'd0 : idx + 3'd1;
            if (frame_wrap) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

    logic [3:0]  nib;
    logic        dp_bit, blink_sel, lz_sel, zero_tail, blank, lit_window;
    logic [31:0] on_limit;
    logic [6:0]  seg_code, seg_next;
    logic        dp_next;
    logic [7:0]  an_next;

    // Walk from the top digit down so zero_tail means "this and all higher nibbles are 0".
    always_comb begin
        nib       = '0;
        dp_bit    = 1'b0;
        blink_sel = 1'b0;
        lz_sel    = 1'b0;
        zero_tail = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_tail = zero_tail & (shadow_data[4*i +: 4] == 4'h0);
            if (idx == 3'(i)) begin
                nib       = shadow_data[4*i +: 4];
                dp_bit    = shadow_dp[i];
                blink_sel = blink_en[i];
                lz_sel    = (i != 0) && zero_tail;
            end
        end
    end

    always_comb begin
        unique case (nib)
            4'h0: seg_code = 7'b0000001;
            4'h1: seg_code = 7'b1001111;
            4'h2: seg_code = 7'b0010010;
            4'h3: seg_code = 7'b0000110;
            4'h4: seg_code = 7'b1001100;
            4'h5: seg_code = 7'b0100100;
            4'h6: seg_code = 7'b0100000;
            4'h7: seg_code = 7'b0001111;
            4'h8: seg_code = 7'b0000000;
            4'h9: seg_code = 7'b0000100;
            4'hA: seg_code = 7'b0001000;
            4'hB: seg_code = 7'b1100000;
            4'hC: seg_code = 7'b0110001;
            4'hD: seg_code = 7'b1000010;
            4'hE: seg_code = 7'b0110000;
            default: seg_code = 7'b0111000;
        endcase
    end

    always_comb begin
        blank      = (blink_sel && blink_phase) || (blank_lz && lz_sel);
        on_limit   = (32'(brightness) + 32'd1) * 32'(STEP);
        lit_window = 32'(presc) < on_limit;
        seg_next   = blank ? 7'b1111111 : seg_code;
        dp_next    = blank ? 1'b1 : ~dp_bit;
        an_next    = 8'hFF;
        if (lit_window && !blank)
            an_next[idx] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            segments   <= 7'b1111111;
            dp         <= 1'b1;
            anodos     <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            segments   <= seg_next;
            dp         <= dp_next;
            anodos     <= an_next;
            frame_done <= frame_wrap;
        end
    end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8, number of scanned digits (legal 1..8).
REQ-002 SHALL have parameter DIV_MAX, default 100000, clock cycles per digit slot (legal: multiple of 2**BRIGHT_BITS, >= 2**BRIGHT_BITS).
REQ-003 SHALL have parameter BRIGHT_BITS, default 3, width of the brightness control.
REQ-004 SHALL have parameter BLINK_FRAMES, default 64, full scan frames per blink half-period (>= 1).
REQ-005 SHALL have port clock  in  1  single system clock; all state on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port load  in  1  when high at a clock edge, captures data_in and dp_in.
REQ-008 SHALL have port data_in  in  4*N_DIGITS  hex nibbles; nibble i = bits [4i+3:4i] shown on digit i.
REQ-009 SHALL have port dp_in  in  N_DIGITS  decimal point request per digit, 1 = lit.
REQ-010 SHALL have port blank_lz  in  1  1 = leading-zero blanking enabled.
REQ-011 SHALL have port blink_en  in  N_DIGITS  1 = digit i blinks.
REQ-012 SHALL have port brightness  in  BRIGHT_BITS  on-time level; 0 = dimmest, all-ones = full slot.
REQ-013 SHALL have port segments  out  7  {CA,CB,CC,CD,CE,CF,CG}, active-low.
REQ-014 SHALL have port dp  out  1  decimal point segment, active-low.
REQ-015 SHALL have port anodos  out  8  {AN7..AN0}, active-low, at most one low at a time.
REQ-016 SHALL have port frame_done  out  1  one-cycle pulse at the end of each full scan frame.

Function
REQ-017 Shadow registers SHALL capture data_in/dp_in on every edge with load=1; the display SHALL use only shadow contents.
REQ-018 Prescaler SHALL count 0..DIV_MAX-1 and wrap; the slot tick SHALL be asserted when prescaler == DIV_MAX-1.
REQ-019 Digit index SHALL advance on each slot tick, 0,1,..,N_DIGITS-1, then wrap to 0.
REQ-020 frame_done SHALL pulse for exactly one cycle when the index wraps N_DIGITS-1 -> 0.
REQ-021 Frame counter SHALL count completed frames 0..BLINK_FRAMES-1; on wrap, blink_phase SHALL toggle.
REQ-022 Digit i SHALL be shown blank (anode high) when blink_en[i]=1 and blink_phase=1.
REQ-023 With blank_lz=1, digit i>0 SHALL be blank when shadow nibbles i..N_DIGITS-1 are all zero; digit 0 SHALL never be blanked by this rule.
REQ-024 Active digit's anode SHALL be low only while prescaler < (brightness+1)*(DIV_MAX/2**BRIGHT_BITS); otherwise all anodes high.
REQ-025 segments SHALL encode the active nibble 0-9,A,b,C,d,E,F (0 = 0000001, 8 = 0000000, F = 0111000); dp SHALL be ~dp_in shadow bit of the active digit.
REQ-026 A blanked digit SHALL drive segments=1111111 and dp=1 in addition to its anode high.
REQ-027 anodos bits at index >= N_DIGITS SHALL be held 1 permanently.
REQ-028 All outputs SHALL be registered: output at cycle k+1 reflects internal state at cycle k; segments, dp and anodos SHALL change on the same edge.
REQ-029 Load coinciding with a slot tick SHALL be honoured; the new shadow value SHALL appear no later than 2 cycles after the load edge.
REQ-030 brightness and blank_lz SHALL take effect on the next cycle without restarting the scan.

Reset
REQ-031 On reset low, all state SHALL clear immediately: prescaler, index, frame counter, blink_phase = 0; shadows = 0.
REQ-032 During reset: segments = 1111111, dp = 1, anodos = 11111111, frame_done = 0.
REQ-033 Reset assertion mid-frame SHALL abort the scan; after release, scanning SHALL restart at digit 0, prescaler 0.

Verification (N_DIGITS=4, DIV_MAX=8, BRIGHT_BITS=2, BLINK_FRAMES=2 unless noted)
REQ-034 Load data_in=16'h1A3F, brightness=3 -> slots of 8 cycles show anodos 11111110/F,11111101/3,11111011/A,11110111/1; anodos[7:4]=1111 always; frame_done every 32 cycles.
REQ-035 data_in=16'h0005, blank_lz=1 -> digits 3..1 blank (anode high, segments 1111111), digit 0 shows 0100100; blank_lz=0 -> digits 3..1 show 0000001.
REQ-036 brightness=0 -> each active anode low for prescaler 0..1 only (2 of 8 cycles); brightness=2 -> low for 6 of 8.
REQ-037 blink_en=4'b0100 -> digit 2 visible for frames 0-1, blank for frames 2-3, visible again at frame 4; other digits unaffected.
REQ-038 reset pulled low in slot of digit 2 -> outputs go to reset values before next edge; after release first active anode is 11111110 with shadow = 0 (segments 0000001).
REQ-039 load=1 with data_in=16'hFFFF on the tick edge ending digit 0 -> digit 1 slot shows 0111000 within 2 cycles of the load edge.
